dcpu_timer: RTL and testbench

- Memory-mapped 16-bit down-counting timer and interrupt source on the dcpu bus.
- Acts as a bus responder: it decodes the CPU address and read/write, and returns register contents on a read.
- It drives the CPU interrupt input i_int via o_int.
- A prescaler divides the clock, and the timer supports one-shot and auto-reload modes.
- Interrupt pending status is cleared by writing 1 (W1C).

---
 rtl/dcpu_timer.sv | 171 +++++++++++++++++
 tb/tb_dcpu_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dcpu_timer
//  Description : Memory-mapped 16-bit down-counting timer with prescaler,
//                one-shot / auto-reload modes and a W1C interrupt source.
//  Revision    : 1.0  - initial release
// ============================================================================
module dcpu_timer #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          PRESCALE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    input  logic        i_rw,
    input  logic        i_cs,
    output logic        o_sel,
    output logic        o_int
);

    localparam logic [2:0] c_OFF_CTRL   = 3'd0;
    localparam logic [2:0] c_OFF_STATUS = 3'd1;
    localparam logic [2:0] c_OFF_RELOAD = 3'd2;
    localparam logic [2:0] c_OFF_COUNT  = 3'd3;
    localparam logic [2:0] c_OFF_PRESC  = 3'd4;

    // Architectural registers
    logic                  r_en;
    logic                  r_auto;
    logic                  r_ie;
    logic                  r_pend;
    logic                  r_ovf;
    logic [15:0]           r_reload;
    logic [15:0]           r_count;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;

    // Decode and event wires
    logic                  w_sel;
    logic                  w_we;
    logic [2:0]            w_off;
    logic                  w_wr_ctrl;
    logic                  w_wr_status;
    logic                  w_wr_reload;
    logic                  w_wr_count;
    logic                  w_wr_presc;
    logic                  w_tick;
    logic                  w_expire;

    // Next-state wires
    logic                  w_en_nxt;
    logic                  w_auto_nxt;
    logic                  w_ie_nxt;
    logic                  w_pend_nxt;
    logic                  w_ovf_nxt;
    logic [15:0]           w_reload_nxt;
    logic [15:0]           w_count_nxt;
    logic [PRESCALE_W-1:0] w_presc_nxt;
    logic [PRESCALE_W-1:0] w_pcnt_nxt;

    assign w_sel       = (i_addr[15:3] == BASE_ADDR[15:3]);
    assign w_off       = i_addr[2:0];
    assign w_we        = i_cs & w_sel & ~i_rw;
    assign w_wr_ctrl   = w_we & (w_off == c_OFF_CTRL);
    assign w_wr_status = w_we & (w_off == c_OFF_STATUS);
    assign w_wr_reload = w_we & (w_off == c_OFF_RELOAD);
    assign w_wr_count  = w_we & (w_off == c_OFF_COUNT);
    assign w_wr_presc  = w_we & (w_off == c_OFF_PRESC);

    // A tick fires on the cycle the prescaler counter reaches the divisor.
    assign w_tick   = r_en & (r_pcnt == r_prescale);
    // A COUNT write in the same cycle suppresses both decrement and expiry.
    assign w_expire = w_tick & ~w_wr_count & (r_count == 16'd0);

    assign o_sel = w_sel;
    assign o_int = r_pend & r_ie;

    // Next-state computation; bus writes take priority over timer events,
    // except that an expiry always sets PEND.
    always_comb begin
        w_en_nxt     = r_en;
        w_auto_nxt   = r_auto;
        w_ie_nxt     = r_ie;
        w_reload_nxt = r_reload;
        w_count_nxt  = r_count;
        w_presc_nxt  = r_prescale;
        w_pcnt_nxt   = r_pcnt;

        if (w_wr_ctrl) begin
            w_en_nxt   = i_dat[0];
            w_auto_nxt = i_dat[1];
            w_ie_nxt   = i_dat[2];
        end else if (w_expire && !r_auto) begin
            w_en_nxt = 1'b0;
        end

        if (w_wr_reload) begin
            w_reload_nxt = i_dat;
        end

        if (w_wr_presc) begin
            w_presc_nxt = i_dat[PRESCALE_W-1:0];
        end

        // Auto-reload uses the RELOAD value held before any concurrent write.
        if (w_wr_count) begin
            w_count_nxt = i_dat;
        end else if (w_tick) begin
            if (r_count != 16'd0) begin
                w_count_nxt = r_count - 16'd1;
            end else if (r_auto) begin
                w_count_nxt = r_reload;
            end
        end

        // OVF looks at PEND before any same-cycle clear.
        w_pend_nxt = w_expire | (r_pend & ~(w_wr_status & i_dat[0]));
        w_ovf_nxt  = (w_expire & r_pend) | (r_ovf & ~(w_wr_status & i_dat[1]));

        // Counter sits at zero while disabled, so enabling starts a fresh period.
        if (w_wr_count || !r_en || !w_en_nxt || w_tick) begin
            w_pcnt_nxt = '0;
        end else begin
            w_pcnt_nxt = r_pcnt + 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_ie       <= 1'b0;
            r_pend     <= 1'b0;
            r_ovf      <= 1'b0;
            r_reload   <= 16'hFFFF;
            r_count    <= 16'd0;
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            r_en       <= w_en_nxt;
            r_auto     <= w_auto_nxt;
            r_ie       <= w_ie_nxt;
            r_pend     <= w_pend_nxt;
            r_ovf      <= w_ovf_nxt;
            r_reload   <= w_reload_nxt;
            r_count    <= w_count_nxt;
            r_prescale <= w_presc_nxt;
            r_pcnt     <= w_pcnt_nxt;
        end
    end

    // Read mux; unselected or unmapped reads return zero.
    always_comb begin
        o_dat = 16'd0;
        if (w_sel) begin
            case (w_off)
                c_OFF_CTRL:   o_dat = {13'd0, r_ie, r_auto, r_en};
                c_OFF_STATUS: o_dat = {14'd0, r_ovf, r_pend};
                c_OFF_RELOAD: o_dat = r_reload;
                c_OFF_COUNT:  o_dat = r_count;
                c_OFF_PRESC:  o_dat = 16'(r_prescale);
                default:      o_dat = 16'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcpu_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcpu_timer
//  Description : Directed scenarios plus randomized bus traffic checked
//                against a behavioural model of the timer.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_dcpu_timer;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk;
    logic        reset_n;
    logic [15:0] addr;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic        rw;
    logic        cs;
    logic        sel;
    logic        intr;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit          m_en, m_auto, m_ie, m_pend, m_ovf;
    logic [15:0] m_reload, m_count;
    logic [7:0]  m_presc;
    int          m_phase;

    dcpu_timer #(.BASE_ADDR(BASE), .PRESCALE_W(8)) u_dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_addr    (addr),
        .i_dat     (wdat),
        .o_dat     (rdat),
        .i_rw      (rw),
        .i_cs      (cs),
        .o_sel     (sel),
        .o_int     (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_ovf = 0;
        m_reload = 16'hFFFF; m_count = 16'd0; m_presc = 8'd0; m_phase = 0;
    endtask

    // One clock of the timer rules, applied to the bus inputs of that cycle.
    task automatic model_step(input logic c, input logic r, input logic [15:0] a, input logic [15:0] d);
        bit wr, tick, cnt_wr, expire, old_en, old_pend, clr_p, clr_o;
        int off;
        logic [15:0] old_reload;
        wr         = c && !r && (a[15:3] == BASE[15:3]);
        off        = int'(a[2:0]);
        tick       = m_en && (m_phase == int'(m_presc));
        cnt_wr     = wr && off == 3;
        expire     = tick && !cnt_wr && m_count == 0;
        old_en     = m_en;
        old_pend   = m_pend;
        old_reload = m_reload;
        clr_p      = wr && off == 1 && d[0];
        clr_o      = wr && off == 1 && d[1];

        if (cnt_wr) m_count = d;
        else if (tick) begin
            if (m_count != 0) m_count = m_count - 1;
            else if (m_auto) m_count = old_reload;
        end
        if (wr && off == 0) begin
            m_en = d[0]; m_auto = d[1]; m_ie = d[2];
        end else if (expire && !m_auto) m_en = 0;
        m_ovf  = (expire && old_pend) || (m_ovf && !clr_o);
        m_pend = expire || (m_pend && !clr_p);
        if (wr && off == 2) m_reload = d;
        if (wr && off == 4) m_presc = d[7:0];
        if (cnt_wr || !old_en || !m_en || tick) m_phase = 0;
        else m_phase = m_phase + 1;
    endtask

    function automatic logic [15:0] model_rd(input int off);
        case (off)
            0: return {13'd0, m_ie, m_auto, m_en};
            1: return {14'd0, m_ovf, m_pend};
            2: return m_reload;
            3: return m_count;
            4: return {8'd0, m_presc};
            default: return 16'd0;
        endcase
    endfunction

    // Drive one bus cycle across a rising edge; returns at the next falling edge.
    task automatic cyc(input logic c, input logic r, input logic [15:0] a, input logic [15:0] d);
        cs = c; rw = r; addr = a; wdat = d;
        model_step(c, r, a, d);
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic wr_reg(input int off, input logic [15:0] d);
        cyc(1'b1, 1'b0, BASE | 16'(off), d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, BASE, 16'd0);
    endtask

    // Combinational read without a clock edge.
    task automatic rd(input int off, output logic [15:0] v);
        cs = 1'b0; rw = 1'b1; addr = BASE | 16'(off);
        #1;
        v = rdat;
    endtask

    logic [15:0] v;
    logic [15:0] exp_rst [8];

    initial begin
        exp_rst = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        reset_n = 1'b0; cs = 1'b0; rw = 1'b1; addr = 16'd0; wdat = 16'd0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset values and decode window
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            check_eq($sformatf("rst_rd%0d", i), v, exp_rst[i]);
            check_eq($sformatf("sel_%0d", i), {15'd0, sel}, 16'd1);
        end
        check_eq("rst_int", {15'd0, intr}, 16'd0);
        addr = 16'hFEFF; #1;
        check_eq("sel_feff", {15'd0, sel}, 16'd0);
        check_eq("dat_feff", rdat, 16'd0);
        @(negedge clk);

        // One-shot
        wr_reg(4, 16'd0);
        wr_reg(3, 16'd3);
        wr_reg(0, 16'd5);
        rd(3, v); check_eq("os_cnt3", v, 16'd3);
        idle(1); rd(3, v); check_eq("os_cnt2", v, 16'd2);
        idle(1); rd(3, v); check_eq("os_cnt1", v, 16'd1);
        idle(1); rd(3, v); check_eq("os_cnt0", v, 16'd0);
        check_eq("os_nopend", {15'd0, intr}, 16'd0);
        idle(1);
        rd(1, v); check_eq("os_pend", v, 16'd1);
        rd(0, v); check_eq("os_ctrl", v, 16'd4);
        rd(3, v); check_eq("os_hold", v, 16'd0);
        check_eq("os_int", {15'd0, intr}, 16'd1);
        idle(1); rd(1, v); check_eq("os_noovf", v, 16'd1);
        wr_reg(1, 16'd3); rd(1, v); check_eq("os_clr", v, 16'd0);

        // Auto-reload with prescaler of 4
        wr_reg(4, 16'd3);
        wr_reg(2, 16'd1);
        wr_reg(3, 16'd1);
        wr_reg(0, 16'd7);
        idle(7); rd(1, v); check_eq("ar_pre", v, 16'd0);
        idle(1); rd(1, v); check_eq("ar_pend1", v, 16'd1);
        rd(3, v); check_eq("ar_reload", v, 16'd1);
        idle(7); rd(1, v); check_eq("ar_mid", v, 16'd1);
        idle(1); rd(1, v); check_eq("ar_ovf", v, 16'd3);
        check_eq("ar_int", {15'd0, intr}, 16'd1);

        // W1C
        wr_reg(1, 16'd1); rd(1, v); check_eq("w1c_pend", v, 16'd2);
        check_eq("w1c_int", {15'd0, intr}, 16'd0);
        wr_reg(1, 16'd2); rd(1, v); check_eq("w1c_ovf", v, 16'd0);

        // Collisions: clear on expiry, count write on tick
        idle(5);
        wr_reg(1, 16'd1); rd(1, v); check_eq("col_pend", v, 16'd1);
        idle(3);
        wr_reg(3, 16'd5); rd(3, v); check_eq("col_cnt", v, 16'd5);
        idle(3); rd(3, v); check_eq("col_hold", v, 16'd5);
        idle(1); rd(3, v); check_eq("col_dec", v, 16'd4);

        // Asynchronous reset between edges
        check_eq("ar_int_pre", {15'd0, intr}, 16'd1);
        #1 reset_n = 1'b0;
        model_reset();
        #1 check_eq("async_int", {15'd0, intr}, 16'd0);
        rd(3, v); check_eq("async_cnt", v, 16'd0);
        rd(0, v); check_eq("async_ctrl", v, 16'd0);
        rd(2, v); check_eq("async_rel", v, 16'hFFFF);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int kind, off, roff;
            logic [15:0] d, a;
            kind = int'($urandom_range(0, 9));
            off  = int'($urandom_range(0, 7));
            case (off)
                0: d = 16'($urandom_range(0, 7)) | 16'(($urandom_range(0, 3) != 0) ? 1 : 0);
                1: d = 16'($urandom_range(0, 3));
                2: d = 16'($urandom_range(0, 6));
                3: d = 16'($urandom_range(0, 12));
                4: d = 16'($urandom_range(0, 3));
                default: d = 16'($urandom);
            endcase
            a = BASE | 16'(off);
            if (kind <= 4)      cyc(1'b0, 1'($urandom_range(0, 1)), a, d);
            else if (kind <= 7) cyc(1'b1, 1'b0, a, d);
            else if (kind == 8) cyc(1'b1, 1'b0, 16'hFEF8 | 16'(off), d);
            else                cyc(1'b1, 1'b1, a, d);
            roff = int'($urandom_range(0, 7));
            rd(3, v);    check_eq("rnd_cnt", v, model_rd(3));
            rd(roff, v); check_eq($sformatf("rnd_rd%0d", roff), v, model_rd(roff));
            check_eq("rnd_int", {15'd0, intr}, {15'd0, m_pend & m_ie});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
